// File: rtl/ifu_fetch_buf.sv
// ifu_fetch_buf: registered instruction fetch engine with one outstanding memory request and a DEPTH-entry {pc, inst} queue.
// Define IFU_LINE_REUSE_EN to serve further slots of the last fetched word without a new memory request.
module ifu_fetch_buf #(
    parameter int ADDR_W = 64,
    parameter int DATA_W = 64,
    parameter int INST_W = 32,
    parameter int DEPTH = 4,
    parameter logic [ADDR_W-1:0] RESET_PC = 64'h8000_0000
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              redirect_valid,
    input  logic [ADDR_W-1:0] redirect_pc,
    output logic              mem_req_valid,
    input  logic              mem_req_ready,
    output logic [ADDR_W-1:0] mem_req_addr,
    input  logic              mem_resp_valid,
    input  logic [DATA_W-1:0] mem_resp_data,
    output logic              inst_valid,
    input  logic              inst_ready,
    output logic [INST_W-1:0] inst,
    output logic [ADDR_W-1:0] inst_pc,
    output logic              halt
);
    localparam int NSLOT = DATA_W / INST_W;
    localparam int SLOT_W = NSLOT > 1 ? $clog2(NSLOT) : 1;
    localparam int ILSB = $clog2(INST_W / 8);
    localparam int PTR_W = $clog2(DEPTH);
    localparam logic [ADDR_W-1:0] OFF_MASK = ADDR_W'(DATA_W / 8 - 1);
    localparam logic [ADDR_W-1:0] INST_B = ADDR_W'(INST_W / 8);
    localparam logic [PTR_W:0] FULL = (PTR_W+1)'(DEPTH);

    typedef enum logic [1:0] {IDLE, REQ, WAIT, HALT} state_t;

    state_t state, nstate;
    logic [ADDR_W-1:0] pc, pc_aligned, req_addr;
    logic drop, rd, req_v, push, pop;
    logic [INST_W-1:0] push_inst;
    logic [PTR_W:0] count;
    logic [PTR_W-1:0] wptr, rptr;
    logic [ADDR_W-1:0] q_pc [DEPTH];
    logic [INST_W-1:0] q_inst [DEPTH];
`ifdef IFU_LINE_REUSE_EN
    logic line_valid;
    logic [ADDR_W-1:0] line_addr;
    logic [DATA_W-1:0] line_data;
`endif

    function automatic logic [INST_W-1:0] slot(input logic [DATA_W-1:0] d, input logic [ADDR_W-1:0] a);
        logic [NSLOT-1:0][INST_W-1:0] w;
        w = d;
        return NSLOT > 1 ? w[SLOT_W'(a >> ILSB)] : w[0];
    endfunction

    assign inst_valid = count != '0;
    assign inst = inst_valid ? q_inst[rptr] : '0;
    assign inst_pc = inst_valid ? q_pc[rptr] : '0;
    assign halt = state == HALT;
    assign mem_req_valid = reset && req_v;
    assign mem_req_addr = state == REQ ? req_addr : pc_aligned;
    assign pop = inst_valid && inst_ready && !rd;

    // A redirect in IDLE suppresses the request so no stale address ever leaves the block.
    always_comb begin
        rd = redirect_valid && state != HALT;
        pc_aligned = pc & ~OFF_MASK;
        nstate = state;
        req_v = 1'b0;
        push = 1'b0;
        push_inst = slot(mem_resp_data, pc);
        case (state)
            IDLE: if (!rd) begin
                if (pc == '0) nstate = HALT;
                else if (count < FULL) begin
`ifdef IFU_LINE_REUSE_EN
                    if (line_valid && line_addr == pc_aligned) begin
                        push = 1'b1;
                        push_inst = slot(line_data, pc);
                    end else
`endif
                    begin
                        req_v = 1'b1;
                        nstate = mem_req_ready ? WAIT : REQ;
                    end
                end
            end
            REQ: begin
                req_v = 1'b1;
                if (mem_req_ready) nstate = WAIT;
            end
            WAIT: if (mem_resp_valid) begin
                nstate = IDLE;
                push = !rd && !drop;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state <= IDLE;
            pc <= RESET_PC;
            req_addr <= '0;
            drop <= 1'b0;
            count <= '0;
            wptr <= '0;
            rptr <= '0;
        end else begin
            state <= nstate;
            pc <= rd ? redirect_pc : push ? pc + INST_B : pc;
            if (state == IDLE) req_addr <= pc_aligned;
            drop <= (state == WAIT && mem_resp_valid) ? 1'b0 : (rd && (state == REQ || state == WAIT)) ? 1'b1 : drop;
            wptr <= rd ? '0 : wptr + PTR_W'(push);
            rptr <= rd ? '0 : rptr + PTR_W'(pop);
            count <= rd ? '0 : count + (PTR_W+1)'(push) - (PTR_W+1)'(pop);
        end
    end

    always_ff @(posedge clk) begin
        if (push) begin
            q_pc[wptr] <= pc;
            q_inst[wptr] <= push_inst;
        end
    end

`ifdef IFU_LINE_REUSE_EN
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            line_valid <= 1'b0;
            line_addr <= '0;
            line_data <= '0;
        end else if (rd) begin
            line_valid <= 1'b0;
        end else if (state == WAIT && push) begin
            line_valid <= 1'b1;
            line_addr <= req_addr;
            line_data <= mem_resp_data;
        end
    end
`endif
endmodule

// File: tb/tb_ifu_fetch_buf.sv
// tb_ifu_fetch_buf: directed vectors and corner sequences for ifu_fetch_buf (default build, line reuse off).
module tb_ifu_fetch_buf;
    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic reset, redirect_valid, mem_req_valid, mem_req_ready, mem_resp_valid, inst_valid, inst_ready, halt;
    logic [63:0] redirect_pc, mem_req_addr, mem_resp_data, inst_pc;
    logic [31:0] inst;

    ifu_fetch_buf dut (
        .clk(clk), .reset(reset),
        .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
        .mem_req_valid(mem_req_valid), .mem_req_ready(mem_req_ready), .mem_req_addr(mem_req_addr),
        .mem_resp_valid(mem_resp_valid), .mem_resp_data(mem_resp_data),
        .inst_valid(inst_valid), .inst_ready(inst_ready), .inst(inst), .inst_pc(inst_pc),
        .halt(halt)
    );

    localparam logic [63:0] RDATA = 64'hAAAA_BBBB_1111_2222;

    int n_cmp = 0, n_bad = 0, lat = 1, pend = 0, nvalid = 0;
    logic [63:0] req_log[$];
    logic [63:0] pop_pc[$];
    logic [31:0] pop_inst[$];
    logic s_rv, s_iv, s_halt;
    logic [63:0] s_ra, s_ipc;
    logic [31:0] s_inst;

    typedef struct {
        logic        rdy;
        logic        rv;
        logic [63:0] ra;
        logic        iv;
        logic [31:0] ins;
        logic [63:0] ipc;
    } vec_t;
    vec_t tbl [7];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic sample();
        s_rv = mem_req_valid;
        s_ra = mem_req_addr;
        s_iv = inst_valid;
        s_inst = inst;
        s_ipc = inst_pc;
        s_halt = halt;
    endtask

    // One clock: sample at negedge, then play the memory (fixed latency, one response per handshake).
    task automatic cyc();
        logic hs;
        @(negedge clk);
        sample();
        hs = s_rv && mem_req_ready;
        if (s_rv) nvalid++;
        if (hs) req_log.push_back(s_ra);
        if (s_iv && inst_ready && !redirect_valid) begin
            pop_pc.push_back(s_ipc);
            pop_inst.push_back(s_inst);
        end
        @(posedge clk);
        #1;
        mem_resp_valid = 1'b0;
        if (hs) pend = lat;
        if (pend > 0) begin
            pend--;
            if (pend == 0) begin
                mem_resp_valid = 1'b1;
                mem_resp_data = RDATA;
            end
        end
    endtask

    task automatic do_reset();
        reset = 1'b0;
        redirect_valid = 1'b0;
        redirect_pc = '0;
        mem_req_ready = 1'b1;
        mem_resp_valid = 1'b0;
        mem_resp_data = '0;
        inst_ready = 1'b0;
        pend = 0;
        @(negedge clk);
        sample();
        @(posedge clk);
        #1;
        reset = 1'b1;
        req_log.delete();
        pop_pc.delete();
        pop_inst.delete();
        nvalid = 0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish within the time limit");
        $fatal(1, "timeout");
    end

    initial begin
        tbl[0] = '{1'b1, 1'b1, 64'h8000_0000, 1'b0, 32'h0, 64'h0};
        tbl[1] = '{1'b1, 1'b0, 64'h0,         1'b0, 32'h0, 64'h0};
        tbl[2] = '{1'b1, 1'b1, 64'h8000_0000, 1'b1, 32'h1111_2222, 64'h8000_0000};
        tbl[3] = '{1'b1, 1'b0, 64'h0,         1'b0, 32'h0, 64'h0};
        tbl[4] = '{1'b1, 1'b1, 64'h8000_0008, 1'b1, 32'hAAAA_BBBB, 64'h8000_0004};
        tbl[5] = '{1'b1, 1'b0, 64'h0,         1'b0, 32'h0, 64'h0};
        tbl[6] = '{1'b1, 1'b1, 64'h8000_0008, 1'b1, 32'h1111_2222, 64'h8000_0008};

        do_reset();
        chk("reset.req_valid", 64'(s_rv), 0);
        chk("reset.inst_valid", 64'(s_iv), 0);
        chk("reset.inst", 64'(s_inst), 0);
        chk("reset.inst_pc", s_ipc, 0);
        chk("reset.halt", 64'(s_halt), 0);

        for (int i = 0; i < 7; i++) begin
            inst_ready = tbl[i].rdy;
            cyc();
            chk($sformatf("seq%0d.req_valid", i), 64'(s_rv), 64'(tbl[i].rv));
            if (tbl[i].rv) chk($sformatf("seq%0d.req_addr", i), s_ra, tbl[i].ra);
            chk($sformatf("seq%0d.inst_valid", i), 64'(s_iv), 64'(tbl[i].iv));
            if (tbl[i].iv) begin
                chk($sformatf("seq%0d.inst", i), 64'(s_inst), 64'(tbl[i].ins));
                chk($sformatf("seq%0d.inst_pc", i), s_ipc, tbl[i].ipc);
            end
        end

        // Full queue with decode stalled: exactly DEPTH fetches, then one more per pop.
        do_reset();
        repeat (20) cyc();
        chk("fill.requests", 64'(req_log.size()), 4);
        chk("fill.last_addr", req_log[3], 64'h8000_0008);
        chk("fill.req_idle", 64'(s_rv), 0);
        chk("fill.head_pc", s_ipc, 64'h8000_0000);
        inst_ready = 1'b1;
        cyc();
        inst_ready = 1'b0;
        repeat (12) cyc();
        chk("fill.requests_after_pop", 64'(req_log.size()), 5);
        chk("fill.refill_addr", req_log[4], 64'h8000_0010);
        chk("fill.new_head_pc", s_ipc, 64'h8000_0004);
        chk("fill.new_head_inst", 64'(s_inst), 64'hAAAA_BBBB);

        // Redirect in WAIT coinciding with the response.
        do_reset();
        inst_ready = 1'b1;
        cyc();
        redirect_valid = 1'b1;
        redirect_pc = 64'h8000_0100;
        cyc();
        redirect_valid = 1'b0;
        cyc();
        chk("wait_rd.inst_valid", 64'(s_iv), 0);
        chk("wait_rd.req_valid", 64'(s_rv), 1);
        chk("wait_rd.req_addr", s_ra, 64'h8000_0100);
        repeat (6) cyc();
        chk("wait_rd.first_pop_pc", pop_pc[0], 64'h8000_0100);
        chk("wait_rd.first_pop_inst", 64'(pop_inst[0]), 64'h1111_2222);

        // Stalled request with a redirect: address held, response dropped.
        do_reset();
        inst_ready = 1'b1;
        redirect_pc = 64'h8000_0200;
        for (int i = 0; i < 4; i++) begin
            redirect_valid = i == 1;
            mem_req_ready = i == 3;
            cyc();
            chk($sformatf("stall%0d.req_valid", i), 64'(s_rv), 1);
            chk($sformatf("stall%0d.req_addr", i), s_ra, 64'h8000_0000);
        end
        redirect_valid = 1'b0;
        mem_req_ready = 1'b1;
        cyc();
        cyc();
        chk("stall.inst_valid", 64'(s_iv), 0);
        chk("stall.next_req_addr", s_ra, 64'h8000_0200);
        repeat (6) cyc();
        chk("stall.req0", req_log[0], 64'h8000_0000);
        chk("stall.req1", req_log[1], 64'h8000_0200);
        chk("stall.first_pop_pc", pop_pc[0], 64'h8000_0200);
        chk("stall.first_pop_inst", 64'(pop_inst[0]), 64'h1111_2222);

        // Redirect to zero halts; halt is sticky and only reset clears it.
        do_reset();
        inst_ready = 1'b1;
        redirect_valid = 1'b1;
        redirect_pc = '0;
        cyc();
        redirect_valid = 1'b0;
        for (int i = 0; i < 2; i++) begin
            cyc();
            if (s_halt) break;
        end
        chk("halt.set", 64'(s_halt), 1);
        redirect_valid = 1'b1;
        redirect_pc = 64'h8000_0000;
        cyc();
        redirect_valid = 1'b0;
        repeat (5) cyc();
        chk("halt.sticky", 64'(s_halt), 1);
        chk("halt.no_requests", 64'(nvalid), 0);
        chk("halt.inst_valid", 64'(s_iv), 0);
        do_reset();
        chk("halt.reset_clears", 64'(s_halt), 0);
        cyc();
        chk("halt.restart_req", 64'(s_rv), 1);
        chk("halt.restart_addr", s_ra, 64'h8000_0000);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
